// File: rtl/fpu_mon_pkg.sv
// Shared types and constants for the FPU exception-flag monitor.
package fpu_mon_pkg;

  localparam int NUM_CHK = 7;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011
  } fpu_op_e;

  typedef enum logic [2:0] {
    CHK_DBZ      = 3'd0,
    CHK_SUB_ZERO = 3'd1,
    CHK_MUL_ZERO = 3'd2,
    CHK_INF_PROP = 3'd3,
    CHK_INVALID  = 3'd4,
    CHK_OVF_UNF  = 3'd5,
    CHK_NAN_IN   = 3'd6
  } chk_id_e;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic sign;
  } fp_class_t;

endpackage

// File: rtl/fpu_operand_classify.sv
// Combinational IEEE-754 operand classifier: zero / inf / nan / sign.
module fpu_operand_classify
  import fpu_mon_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output fp_class_t            cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             man_nz;
  logic             exp_max;

  assign exp_f   = op[MAN_W +: EXP_W];
  assign man_f   = op[MAN_W-1:0];
  assign man_nz  = |man_f;
  assign exp_max = &exp_f;

  // Sign is passed through; zero class covers both +0 and -0.
  always_comb begin
    cls.zero = (exp_f == '0) && !man_nz;
    cls.inf  = exp_max && !man_nz;
    cls.nan  = exp_max && man_nz;
    cls.sign = op[EXP_W+MAN_W];
  end

endmodule

// File: rtl/fpu_flag_monitor.sv
// Delay-line checker of FPU exception flags against IEEE-754 special cases.
module fpu_flag_monitor
  import fpu_mon_pkg::*;
#(
  parameter int                 EXP_W   = 8,
  parameter int                 MAN_W   = 23,
  parameter int                 LATENCY = 4,
  parameter int                 CNT_W   = 16,
  parameter logic [NUM_CHK-1:0] CHK_EN  = 7'h7F
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     mon_en,
  input  logic                     in_valid,
  input  logic [EXP_W+MAN_W:0]     opa,
  input  logic [EXP_W+MAN_W:0]     opb,
  input  logic [2:0]               fpu_op,
  input  logic                     inf,
  input  logic                     qnan,
  input  logic                     overflow,
  input  logic                     underflow,
  input  logic                     zero,
  input  logic                     div_by_zero,
  output logic [NUM_CHK-1:0]       err_vec,
  output logic                     err_any,
  output logic [NUM_CHK*CNT_W-1:0] viol_cnt,
  output logic [CNT_W-1:0]         chk_cnt,
  output logic                     first_valid,
  output logic [2:0]               first_id,
  output logic [EXP_W+MAN_W:0]     first_opa,
  output logic [EXP_W+MAN_W:0]     first_opb,
  output logic [2:0]               first_op
);

  localparam int W = 1 + EXP_W + MAN_W;

  // Out-of-range latency stops elaboration.
  if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
    $error("fpu_flag_monitor: LATENCY must be 1..16");
  end

  logic [LATENCY-1:0]          vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][W-1:0]   opa_pipe_q, opa_pipe_d;
  logic [LATENCY-1:0][W-1:0]   opb_pipe_q, opb_pipe_d;
  logic [LATENCY-1:0][2:0]     op_pipe_q,  op_pipe_d;

  logic                        mat_vld;
  logic [W-1:0]                mat_opa, mat_opb;
  logic [2:0]                  mat_op;
  fp_class_t                   ca, cb;
  logic                        fin_a, fin_b;
  logic [NUM_CHK-1:0]          raw, viol;

  logic [NUM_CHK-1:0]              err_vec_q, err_vec_d;
  logic [NUM_CHK-1:0][CNT_W-1:0]   viol_cnt_q, viol_cnt_d;
  logic [CNT_W-1:0]                chk_cnt_q, chk_cnt_d;
  logic                            first_valid_q, first_valid_d;
  logic [2:0]                      first_id_q, first_id_d, low_id;
  logic [W-1:0]                    first_opa_q, first_opa_d;
  logic [W-1:0]                    first_opb_q, first_opb_d;
  logic [2:0]                      first_op_q, first_op_d;

  // Delay line: stage 0 takes the new issue (or a bubble), everything else shifts up.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    opa_pipe_d = opa_pipe_q;
    opb_pipe_d = opb_pipe_q;
    op_pipe_d  = op_pipe_q;
    for (int i = LATENCY - 1; i > 0; i--) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      opa_pipe_d[i] = opa_pipe_q[i-1];
      opb_pipe_d[i] = opb_pipe_q[i-1];
      op_pipe_d[i]  = op_pipe_q[i-1];
    end
    vld_pipe_d[0] = in_valid & mon_en;
    opa_pipe_d[0] = opa;
    opb_pipe_d[0] = opb;
    op_pipe_d[0]  = fpu_op;
  end

  assign mat_vld = vld_pipe_q[LATENCY-1];
  assign mat_opa = opa_pipe_q[LATENCY-1];
  assign mat_opb = opb_pipe_q[LATENCY-1];
  assign mat_op  = op_pipe_q[LATENCY-1];

  fpu_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.op(mat_opa), .cls(ca));
  fpu_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.op(mat_opb), .cls(cb));

  assign fin_a = !ca.inf && !ca.nan;
  assign fin_b = !cb.inf && !cb.nan;

  // Special-case implications on the matured entry; ops 1xx fall through to check 5 only.
  always_comb begin
    raw = '0;
    raw[CHK_DBZ] = (mat_op == OP_DIV) && cb.zero && fin_a && !ca.zero
                   && !(div_by_zero && inf);
    raw[CHK_SUB_ZERO] = (mat_op == OP_SUB) && (mat_opa == mat_opb) && fin_a && fin_b
                        && !zero;
    raw[CHK_MUL_ZERO] = (mat_op == OP_MUL) && (ca.zero || cb.zero) && fin_a && fin_b
                        && !zero;
    raw[CHK_INF_PROP] = ((mat_op == OP_ADD) || (mat_op == OP_SUB))
                        && ((ca.inf && fin_b) || (cb.inf && fin_a)) && !inf;
    raw[CHK_INVALID]  = (((mat_op == OP_ADD) && ca.inf && cb.inf && (ca.sign != cb.sign))
                      || ((mat_op == OP_SUB) && ca.inf && cb.inf && (ca.sign == cb.sign))
                      || ((mat_op == OP_MUL) && ((ca.zero && cb.inf) || (ca.inf && cb.zero)))
                      || ((mat_op == OP_DIV) && ((ca.zero && cb.zero) || (ca.inf && cb.inf))))
                      && !qnan;
    raw[CHK_OVF_UNF]  = overflow && underflow;
    raw[CHK_NAN_IN]   = !mat_op[2] && (ca.nan || cb.nan) && !qnan;
  end

  assign viol = raw & CHK_EN & {NUM_CHK{mat_vld}};

  // Lowest violated id wins the first-failure capture.
  always_comb begin
    low_id = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (viol[i]) low_id = 3'(i);
    end
  end

  // Sticky flags, saturating counters and first capture; clr overrides a same-edge update.
  always_comb begin
    err_vec_d     = err_vec_q | viol;
    viol_cnt_d    = viol_cnt_q;
    chk_cnt_d     = chk_cnt_q;
    first_valid_d = first_valid_q;
    first_id_d    = first_id_q;
    first_opa_d   = first_opa_q;
    first_opb_d   = first_opb_q;
    first_op_d    = first_op_q;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (viol[i] && !(&viol_cnt_q[i])) viol_cnt_d[i] = viol_cnt_q[i] + CNT_W'(1);
    end
    if (mat_vld && !(&chk_cnt_q)) chk_cnt_d = chk_cnt_q + CNT_W'(1);
    if (!first_valid_q && (|viol)) begin
      first_valid_d = 1'b1;
      first_id_d    = low_id;
      first_opa_d   = mat_opa;
      first_opb_d   = mat_opb;
      first_op_d    = mat_op;
    end
    if (clr) begin
      err_vec_d     = '0;
      viol_cnt_d    = '0;
      chk_cnt_d     = '0;
      first_valid_d = 1'b0;
      first_id_d    = '0;
      first_opa_d   = '0;
      first_opb_d   = '0;
      first_op_d    = '0;
    end
  end

  // State registers; reset also discards every in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q    <= '0;
      opa_pipe_q    <= '0;
      opb_pipe_q    <= '0;
      op_pipe_q     <= '0;
      err_vec_q     <= '0;
      viol_cnt_q    <= '0;
      chk_cnt_q     <= '0;
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
      first_opa_q   <= '0;
      first_opb_q   <= '0;
      first_op_q    <= '0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      opa_pipe_q    <= opa_pipe_d;
      opb_pipe_q    <= opb_pipe_d;
      op_pipe_q     <= op_pipe_d;
      err_vec_q     <= err_vec_d;
      viol_cnt_q    <= viol_cnt_d;
      chk_cnt_q     <= chk_cnt_d;
      first_valid_q <= first_valid_d;
      first_id_q    <= first_id_d;
      first_opa_q   <= first_opa_d;
      first_opb_q   <= first_opb_d;
      first_op_q    <= first_op_d;
    end
  end

  assign err_vec     = err_vec_q;
  assign err_any     = |err_vec_q;
  assign viol_cnt    = viol_cnt_q;
  assign chk_cnt     = chk_cnt_q;
  assign first_valid = first_valid_q;
  assign first_id    = first_id_q;
  assign first_opa   = first_opa_q;
  assign first_opb   = first_opb_q;
  assign first_op    = first_op_q;

endmodule
